// File: rtl/and_gate_pkg.sv
// Shared defaults and helpers for the and2_gate primitive and its hit counter.
package and_gate_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 8;

  // All-ones value of a w-bit counter; computed in 64 bits so w=32 does not overflow.
  function automatic logic [63:0] SAT_MAX(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/and2_gate_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter
  import and_gate_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(SAT_MAX(CNT_W));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != MaxCnt)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/and2_gate.sv
// Bitwise two-input AND with a registered, valid-tagged copy and an all-ones hit counter.
module and2_gate
  import and_gate_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic             out_valid,
  output logic             Y_ALL,
  output logic [CNT_W-1:0] HIT_CNT
);

  logic hit;

  // Purely combinational path; independent of clock and reset.
  assign Y = A & B;

  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      Y_q       <= Y;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign Y_ALL = &Y_q;

  // Reset inside the counter takes priority, so a sample coincident with rst is dropped.
  assign hit = in_valid & (&Y);

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit),
    .cnt (HIT_CNT)
  );

endmodule

// File: tb/tb_and2_gate.sv
// Directed and randomized self-checking bench for and2_gate in three configurations.
module tb_and2_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] a, b;
  logic       iv;

  // WIDTH=1 instance driven from bit 0 of the shared operands
  logic       a1, b1;
  logic       y1, yq1, ov1, yall1;
  logic [7:0] cnt1;
  // WIDTH=4, CNT_W=8
  logic [3:0] y4, yq4;
  logic       ov4, yall4;
  logic [7:0] cnt4;
  // WIDTH=4, CNT_W=2 (saturation)
  logic [3:0] ys, yqs;
  logic       ovs, yalls;
  logic [1:0] cnts;

  assign a1 = a[0];
  assign b1 = b[0];

  and2_gate #(.WIDTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .in_valid(iv),
    .Y(y1), .Y_q(yq1), .out_valid(ov1), .Y_ALL(yall1), .HIT_CNT(cnt1)
  );

  and2_gate #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(iv),
    .Y(y4), .Y_q(yq4), .out_valid(ov4), .Y_ALL(yall4), .HIT_CNT(cnt4)
  );

  and2_gate #(.WIDTH(4), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .A(a), .B(b), .in_valid(iv),
    .Y(ys), .Y_q(yqs), .out_valid(ovs), .Y_ALL(yalls), .HIT_CNT(cnts)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: last accepted result, valid flag, and hit tallies as plain integers
  logic [3:0] m_res;
  logic       m_ov;
  int         m_hits4, m_hits1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":yq4"},   32'(yq4),   32'(m_res));
    chk({tag, ":ov4"},   32'(ov4),   32'(m_ov));
    chk({tag, ":yall4"}, 32'(yall4), 32'(m_res == 4'hF));
    chk({tag, ":cnt4"},  32'(cnt4),  32'(sat(m_hits4, 255)));
    chk({tag, ":yqs"},   32'(yqs),   32'(m_res));
    chk({tag, ":ovs"},   32'(ovs),   32'(m_ov));
    chk({tag, ":yalls"}, 32'(yalls), 32'(m_res == 4'hF));
    chk({tag, ":cnts"},  32'(cnts),  32'(sat(m_hits4, 3)));
    chk({tag, ":yq1"},   32'(yq1),   32'(m_res[0]));
    chk({tag, ":ov1"},   32'(ov1),   32'(m_ov));
    chk({tag, ":yall1"}, 32'(yall1), 32'(m_res[0]));
    chk({tag, ":cnt1"},  32'(cnt1),  32'(sat(m_hits1, 255)));
  endtask

  // One clock cycle: drive at negedge, check combinational Y, then registered state after posedge
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [3:0] av, input logic [3:0] bv);
    @(negedge clk);
    rst = r;
    iv  = v;
    a   = av;
    b   = bv;
    #1;
    chk({tag, ":y4"}, 32'(y4), 32'(av & bv));
    chk({tag, ":ys"}, 32'(ys), 32'(av & bv));
    chk({tag, ":y1"}, 32'(y1), 32'(av[0] & bv[0]));
    @(posedge clk);
    if (r) begin
      m_res   = 4'h0;
      m_ov    = 1'b0;
      m_hits4 = 0;
      m_hits1 = 0;
    end else if (v) begin
      m_res = av & bv;
      m_ov  = 1'b1;
      if (m_res == 4'hF) m_hits4++;
      if (m_res[0])      m_hits1++;
    end else begin
      m_ov = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] tt;
    logic       r, v;
    logic [3:0] ra, rb;
    tt  = 4'b1000;
    rst = 1'b0;
    iv  = 1'b0;
    a   = '0;
    b   = '0;

    // 1. WIDTH=1 truth table, purely combinational
    for (int i = 0; i < 4; i++) begin
      a = {3'b000, 1'(i >> 1)};
      b = {3'b000, 1'(i & 1)};
      #1;
      chk("tt_early", 32'(y1), 32'(tt[i]));
      #8;
      chk("tt_late", 32'(y1), 32'(tt[i]));
      #1;
    end

    // 2. Reset held two clocks with an all-ones sample pending
    step("rst0", 1'b1, 1'b1, 4'hF, 4'hF);
    step("rst1", 1'b1, 1'b1, 4'hF, 4'hF);
    chk("rst_yq4", 32'(yq4), 32'h0);
    chk("rst_ov4", 32'(ov4), 32'h0);
    chk("rst_cnt4", 32'(cnt4), 32'h0);
    chk("rst_y1", 32'(y1), 32'h1);

    // 3. Single capture, then idle hold
    step("cap", 1'b0, 1'b1, 4'b1100, 4'b1010);
    chk("cap_yq4", 32'(yq4), 32'h8);
    chk("cap_ov4", 32'(ov4), 32'h1);
    chk("cap_yall4", 32'(yall4), 32'h0);
    step("hold", 1'b0, 1'b0, 4'h0, 4'h0);
    chk("hold_ov4", 32'(ov4), 32'h0);
    chk("hold_yq4", 32'(yq4), 32'h8);

    // 4. Three hits then a near miss
    for (int i = 0; i < 3; i++) step("hit", 1'b0, 1'b1, 4'hF, 4'hF);
    step("miss", 1'b0, 1'b1, 4'hF, 4'h7);
    chk("hit_cnt4", 32'(cnt4), 32'd3);
    chk("hit_yall4", 32'(yall4), 32'h0);

    // 5. Saturation of the 2-bit counter
    step("sat_rst", 1'b1, 1'b0, 4'h0, 4'h0);
    for (int i = 0; i < 6; i++) step("sat", 1'b0, 1'b1, 4'hF, 4'hF);
    chk("sat_cnts", 32'(cnts), 32'd3);
    chk("sat_cnt4", 32'(cnt4), 32'd6);

    // 6. Reset coincident with an all-ones capture
    step("mid_rst", 1'b1, 1'b1, 4'hF, 4'hF);
    chk("mid_yq4", 32'(yq4), 32'h0);
    chk("mid_cnt4", 32'(cnt4), 32'h0);
    chk("mid_ovs", 32'(ovs), 32'h0);

    // Randomized traffic, biased towards all-ones operands so the counters saturate
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ra = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      rb = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      step("rand", r, v, ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
